// File: rtl/video_pkg.sv
// Shared definitions for the tile-line fetch path: FSM encoding, tile geometry
// and default memory layout of the tile map and pattern table.
package video_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAP,
    ST_PAT,
    ST_EMIT,
    ST_DONE
  } fetch_state_t;

  localparam int TILE_BYTES  = 32;  // 8 rows x 4 bytes per pattern
  localparam int ROW_BYTES   = 4;   // one pattern row, 8 pixels at 4bpp
  localparam int TILE_PIXELS = 8;
  localparam int PIXEL_BITS  = 4;

  localparam int MAP_BASE_DEF     = 0;
  localparam int PATTERN_BASE_DEF = 8192;

endpackage

// File: rtl/pixel_shifter.sv
// One pattern row (4 bytes) loaded byte by byte, then presented as 8 nibbles
// left pixel first (byte0[7:4] .. byte3[3:0]) over a ready/valid handshake.
module pixel_shifter
  import video_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [1:0]            i_load_idx,
  input  logic [7:0]            i_load_data,
  input  logic                  i_emit,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [PIXEL_BITS-1:0] o_data,
  output logic                  o_last_hs
);

  logic [31:0] r_row;
  logic [2:0]  r_pixel;
  logic        w_hs;
  logic [4:0]  w_load_lsb;
  logic [4:0]  w_nib_lsb;

  // byte 0 sits in the top byte so pixel 0 is the top nibble; 3-k == ~k for 2 bits
  assign w_load_lsb = {~i_load_idx, 3'b000};
  assign w_nib_lsb  = {~r_pixel, 2'b00};
  assign w_hs       = i_emit & i_ready;
  assign o_valid    = i_emit;
  assign o_data     = i_emit ? r_row[w_nib_lsb +: PIXEL_BITS] : '0;
  assign o_last_hs  = w_hs & (r_pixel == 3'(TILE_PIXELS - 1));

  // byte loads and pixel counter; counter wraps to 0 after the 8th handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row   <= '0;
      r_pixel <= '0;
    end else begin
      if (i_load) r_row[w_load_lsb +: 8] <= i_load_data;
      if (w_hs)   r_pixel <= r_pixel + 3'd1;
    end
  end

endmodule

// File: rtl/tile_line_fetcher.sv
// Walks one scanline of the tile map: per tile, read the map entry, read the
// 4 pattern bytes of the selected row, then stream 8 pixels downstream.
// RAM read data is combinational, so the address is consumed the same cycle.
module tile_line_fetcher
  import video_pkg::*;
#(
  parameter int Bits         = 16,
  parameter int MapBase      = MAP_BASE_DEF,
  parameter int PatternBase  = PATTERN_BASE_DEF,
  parameter int MapWidth     = 32,
  parameter int TilesPerLine = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      lineY,
  output logic            busy,
  output logic            done,
  output logic [Bits-1:0] memAddress,
  input  logic [7:0]      memData,
  output logic            pixelValid,
  output logic [3:0]      pixelData,
  input  logic            pixelReady
);

  localparam logic [7:0] LAST_COL = 8'(TilesPerLine - 1);

  fetch_state_t    r_state, w_next;
  logic [7:0]      r_line;
  logic [7:0]      r_col;
  logic [7:0]      r_tile;
  logic [1:0]      r_byte;
  logic [Bits-1:0] r_addr_hold;
  logic [Bits-1:0] w_map_addr;
  logic [Bits-1:0] w_pat_addr;
  logic [Bits-1:0] w_addr;
  logic            w_last_hs;

  // all sums wrap at 2^Bits; tile index is zero-extended
  assign w_map_addr = Bits'(MapBase) + Bits'(r_line[7:3]) * Bits'(MapWidth) + Bits'(r_col);
  assign w_pat_addr = Bits'(PatternBase) + Bits'(r_tile) * Bits'(TILE_BYTES)
                    + Bits'(r_line[2:0]) * Bits'(ROW_BYTES) + Bits'(r_byte);

  // next-state and address select; address holds its last value outside MAP/PAT
  always_comb begin
    w_next = r_state;
    w_addr = r_addr_hold;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_MAP;
      ST_MAP: begin
        w_addr = w_map_addr;
        w_next = ST_PAT;
      end
      ST_PAT: begin
        w_addr = w_pat_addr;
        if (r_byte == 2'd3) w_next = ST_EMIT;
      end
      ST_EMIT: if (w_last_hs) w_next = (r_col < LAST_COL) ? ST_MAP : ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // line/column/tile/byte bookkeeping and address hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_line      <= '0;
      r_col       <= '0;
      r_tile      <= '0;
      r_byte      <= '0;
      r_addr_hold <= '0;
    end else begin
      if (r_state == ST_MAP || r_state == ST_PAT) r_addr_hold <= w_addr;
      case (r_state)
        ST_IDLE: if (start) begin
          r_line <= lineY;
          r_col  <= '0;
        end
        ST_MAP: begin
          r_tile <= memData;
          r_byte <= '0;
        end
        ST_PAT:  r_byte <= r_byte + 2'd1;
        ST_EMIT: if (w_last_hs && r_col < LAST_COL) r_col <= r_col + 8'd1;
        default: ;
      endcase
    end
  end

  pixel_shifter u_shift (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_state == ST_PAT),
    .i_load_idx (r_byte),
    .i_load_data(memData),
    .i_emit     (r_state == ST_EMIT),
    .i_ready    (pixelReady),
    .o_valid    (pixelValid),
    .o_data     (pixelData),
    .o_last_hs  (w_last_hs)
  );

  assign memAddress = w_addr;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Bench for tile_line_fetcher: RAM model, line-level pixel reference queue,
// per-cycle address/valid/done expectations when the sink never stalls.
module tb_tile_line_fetcher;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  lineY;
  logic        busy;
  logic        done;
  logic [15:0] memAddress;
  logic [7:0]  memData;
  logic        pixelValid;
  logic [3:0]  pixelData;
  logic        pixelReady;

  logic [7:0]  mem [0:65535];
  logic [3:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_cnt   = 0;
  int          lit_cyc [4];
  int          lit_adr [4];

  assign memData = mem[memAddress];

  tile_line_fetcher dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .lineY     (lineY),
    .busy      (busy),
    .done      (done),
    .memAddress(memAddress),
    .memData   (memData),
    .pixelValid(pixelValid),
    .pixelData (pixelData),
    .pixelReady(pixelReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference layout: map at 0, 32 bytes per map row; patterns at 0x2000, 32 B/tile
  function automatic int map_addr(input int y, input int col);
    return ((y / 8) * 32 + col) & 16'hFFFF;
  endfunction

  function automatic int pat_addr(input int y, input int tile, input int k);
    return (8192 + tile * 32 + (y % 8) * 4 + k) & 16'hFFFF;
  endfunction

  function automatic logic [3:0] model_pix(input int y, input int n);
    int   tile;
    logic [7:0] b;
    tile = int'(mem[map_addr(y, n / 8)]);
    b    = mem[pat_addr(y, tile, (n % 8) / 2)];
    return (n % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  // compare process: every handshake pops the model; stalled pixels must hold
  initial begin
    logic       prev_stall;
    logic [3:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", int'(pixelValid), 1);
          chk("hold_data", int'(pixelData), int'(prev_data));
        end
        if (pixelValid && pixelReady) begin
          if (exp_q.size() == 0) chk("unexpected_pixel", int'(pixelData), -1);
          else chk("pixel", int'(pixelData), int'(exp_q.pop_front()));
          hs_cnt++;
        end
        prev_stall = pixelValid && !pixelReady;
        prev_data  = pixelData;
      end
    end
  end

  // mode 0: ready always 1 (full per-cycle checks); 1: random ready;
  // 2: ready dropped for 5 cycles while pixel 3 of tile 0 is presented
  task automatic run_line(input logic [7:0] y, input int mode, input int mid_start,
                          input int abort_c, output int done_c);
    int   hs0, c, t, ph, ea;
    logic [7:0] tile0;
    hs0    = hs_cnt;
    done_c = -1;
    for (int n = 0; n < 256; n++) exp_q.push_back(model_pix(int'(y), n));
    tile0 = mem[map_addr(int'(y), 0)];
    lineY = y;
    start = 1'b1;
    pixelReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lineY = 8'($urandom);
    c = 1;
    while (done_c < 0 && c <= 6000) begin
      case (mode)
        0:       pixelReady = 1'b1;
        1:       pixelReady = ($urandom_range(0, 3) != 0);
        default: pixelReady = !(c >= 9 && c <= 13);
      endcase
      if (c == mid_start) begin
        start = 1'b1;
        lineY = y ^ 8'h08;
      end else start = 1'b0;
      #1;
      if (c == 1) begin
        chk("map_addr_t0", int'(memAddress), map_addr(int'(y), 0));
        chk("busy_run", int'(busy), 1);
      end
      if (c >= 2 && c <= 5) chk("pat_addr_t0", int'(memAddress), pat_addr(int'(y), int'(tile0), c - 2));
      if (c == 6) chk("first_valid", int'(pixelValid), 1);
      for (int k = 0; k < 4; k++)
        if (c == lit_cyc[k]) chk("lit_addr", int'(memAddress), lit_adr[k]);
      if (mode == 0) begin
        if (c <= 416) begin
          t  = (c - 1) / 13;
          ph = (c - 1) % 13;
          if (ph == 0) ea = map_addr(int'(y), t);
          else ea = pat_addr(int'(y), int'(mem[map_addr(int'(y), t)]), (ph <= 4) ? ph - 1 : 3);
          chk("addr_cyc", int'(memAddress), ea);
          chk("valid_cyc", int'(pixelValid), int'(ph >= 5));
        end else begin
          chk("valid_done", int'(pixelValid), 0);
        end
        chk("done_cyc", int'(done), int'(c == 417));
      end
      if (c == abort_c) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(pixelValid), 0);
        chk("abort_addr", int'(memAddress), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_data", int'(pixelData), 0);
        return;
      end
      if (done) done_c = c;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    if (done_c < 0) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("handshakes", hs_cnt - hs0, 256);
      chk("queue_empty", exp_q.size(), 0);
      chk("busy_after", int'(busy), 0);
      chk("done_pulse", int'(done), 0);
    end
    exp_q.delete();
    for (int k = 0; k < 4; k++) lit_cyc[k] = -1;
  endtask

  initial begin
    int          dc;
    logic [3:0]  pin1 [8];
    logic [3:0]  pin2 [8];
    reset = 1'b1;
    start = 1'b0;
    lineY = '0;
    pixelReady = 1'b0;
    for (int k = 0; k < 4; k++) lit_cyc[k] = -1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h00;  mem[31] = 8'h02;  mem[32] = 8'h03;
    mem[16'h2000] = 8'h08; mem[16'h2001] = 8'h80; mem[16'h2002] = 8'h08; mem[16'h2003] = 8'h80;
    mem[16'h2004] = 8'h77; mem[16'h2005] = 8'h88; mem[16'h2006] = 8'h88; mem[16'h2007] = 8'h88;
    pin1 = '{4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0};
    pin2 = '{4'h7, 4'h7, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(pixelValid), 0);
    chk("rst_data", int'(pixelData), 0);
    chk("rst_addr", int'(memAddress), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", int'(busy), 0);

    // line 0: literal pixels/addresses, done at 417, stray start at cycle 100
    for (int i = 0; i < 8; i++) chk("pin_line0", int'(model_pix(0, i)), int'(pin1[i]));
    lit_cyc = '{1, 2, 5, 405};
    lit_adr = '{16'h0000, 16'h2000, 16'h2003, 16'h2040};
    run_line(8'd0, 0, 100, -1, dc);
    chk("done_cycle", dc, 417);

    // line 1: second pattern row of tile 0
    for (int i = 0; i < 8; i++) chk("pin_line1", int'(model_pix(1, i)), int'(pin2[i]));
    run_line(8'd1, 0, -1, -1, dc);
    chk("done_cycle_l1", dc, 417);

    // line 8: map row 1, tile 3, with a 5-cycle stall on pixel 3
    lit_cyc = '{1, 2, 5, -1};
    lit_adr = '{16'h0020, 16'h2060, 16'h2063, 0};
    run_line(8'd8, 2, -1, -1, dc);
    chk("done_cycle_stall", dc, 422);

    // random lines under random backpressure
    for (int r = 0; r < 3; r++) run_line(8'($urandom), 1, -1, -1, dc);

    // reset during EMIT of tile 5, then a clean full line
    run_line(8'($urandom), 0, -1, 1 + 5 * 13 + 7, dc);
    run_line(8'($urandom), 0, -1, -1, dc);
    chk("done_cycle_after_rst", dc, 417);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
